// File: rtl/bus_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_if_pkg
//  Purpose  : Shared defaults, count-width helper and sticky-flag vector for
//             the per-driver bus FIFO front end.
//  Revision : 1.0  initial release
// ============================================================================
package bus_if_pkg;

    localparam int c_bits  = 32;
    localparam int c_depth = 16;

    // One extra bit so the count can represent "depth" (full) as well as 0.
    function automatic int count_width(input int d);
        return $clog2(d) + 1;
    endfunction

    typedef struct packed {
        logic tx_ovf;
        logic tx_udf;
        logic rx_ovf;
        logic rx_udf;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/sync_fwft_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fwft_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with overflow and
//             underflow event strobes.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fwft_fifo
    import bus_if_pkg::*;
#(
    parameter int bits  = c_bits,
    parameter int depth = c_depth
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr,
    input  logic [bits-1:0]                  wr_data,
    input  logic                             rd,
    output logic [bits-1:0]                  rd_data,
    output logic [count_width(depth)-1:0]    count,
    output logic                             full,
    output logic                             empty,
    output logic                             ovf_evt,
    output logic                             udf_evt
);

    localparam int c_cw = count_width(depth);
    localparam int c_aw = $clog2(depth);
    localparam logic [c_cw-1:0] c_full = c_cw'(depth);

    logic [bits-1:0] r_mem [depth];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;

    logic w_rd_ok;
    logic w_wr_ok;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_full);
    assign w_rd_ok = rd && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr_ok = wr && (!full || w_rd_ok);
    assign ovf_evt = wr && !w_wr_ok;
    assign udf_evt = rd && empty;

    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_drvr_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_drvr_fifo_if
//  Purpose  : Per-driver TX/RX FIFO front end for the bus arbiter, with
//             occupancy counts and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module bus_drvr_fifo_if
    import bus_if_pkg::*;
#(
    parameter int bits  = c_bits,
    parameter int depth = c_depth,
    parameter int cw    = count_width(depth)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_wr,
    input  logic [bits-1:0] host_wr_data,
    output logic            tx_full,
    output logic [cw-1:0]   tx_count,
    output logic            pndng,
    output logic [bits-1:0] D_pop,
    input  logic            pop,
    input  logic            push,
    input  logic [bits-1:0] D_push,
    input  logic            host_rd,
    output logic [bits-1:0] host_rd_data,
    output logic            rx_empty,
    output logic [cw-1:0]   rx_count,
    input  logic            clr_flags,
    output logic            tx_ovf,
    output logic            tx_udf,
    output logic            rx_ovf,
    output logic            rx_udf
);

    flags_t r_flags;
    flags_t w_evt;
    logic   w_tx_empty;

    sync_fwft_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr      (host_wr),
        .wr_data (host_wr_data),
        .rd      (pop),
        .rd_data (D_pop),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (w_tx_empty),
        .ovf_evt (w_evt.tx_ovf),
        .udf_evt (w_evt.tx_udf)
    );

    sync_fwft_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr      (push),
        .wr_data (D_push),
        .rd      (host_rd),
        .rd_data (host_rd_data),
        .count   (rx_count),
        .full    (),
        .empty   (rx_empty),
        .ovf_evt (w_evt.rx_ovf),
        .udf_evt (w_evt.rx_udf)
    );

    assign pndng = !w_tx_empty;

    // A new event in the clearing cycle survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= flags_t'((clr_flags ? 4'b0000 : r_flags) | w_evt);
        end
    end

    assign tx_ovf = r_flags.tx_ovf;
    assign tx_udf = r_flags.tx_udf;
    assign rx_ovf = r_flags.rx_ovf;
    assign rx_udf = r_flags.rx_udf;

endmodule
`default_nettype wire

// File: tb/tb_bus_drvr_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_drvr_fifo_if
//  Purpose  : Directed self-checking bench for bus_drvr_fifo_if.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_drvr_fifo_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_wr;
    logic [31:0] host_wr_data;
    logic        tx_full;
    logic [4:0]  tx_count;
    logic        pndng;
    logic [31:0] D_pop;
    logic        pop;
    logic        push;
    logic [31:0] D_push;
    logic        host_rd;
    logic [31:0] host_rd_data;
    logic        rx_empty;
    logic [4:0]  rx_count;
    logic        clr_flags;
    logic        tx_ovf, tx_udf, rx_ovf, rx_udf;

    int errors = 0;
    int checks = 0;

    bus_drvr_fifo_if #(.bits(32), .depth(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_wr      (host_wr),
        .host_wr_data (host_wr_data),
        .tx_full      (tx_full),
        .tx_count     (tx_count),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .host_rd      (host_rd),
        .host_rd_data (host_rd_data),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .clr_flags    (clr_flags),
        .tx_ovf       (tx_ovf),
        .tx_udf       (tx_udf),
        .rx_ovf       (rx_ovf),
        .rx_udf       (rx_udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        host_wr = 1'b0; pop = 1'b0; push = 1'b0; host_rd = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        host_wr_data = '0;
        D_push = '0;
        idle();
        #12;
        check("rst_pndng",    {31'd0, pndng},    32'd0);
        check("rst_tx_full",  {31'd0, tx_full},  32'd0);
        check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_tx_count", {27'd0, tx_count}, 32'd0);
        check("rst_rx_count", {27'd0, rx_count}, 32'd0);
        check("rst_D_pop",    D_pop,             32'd0);
        check("rst_rd_data",  host_rd_data,      32'd0);
        check("rst_flags",    {28'd0, tx_ovf, tx_udf, rx_ovf, rx_udf}, 32'd0);
        reset = 1'b0;

        // single word through TX
        tick();
        host_wr = 1'b1; host_wr_data = 32'hA5A5_0001;
        tick();
        host_wr = 1'b0;
        check("w1_pndng", {31'd0, pndng}, 32'd1);
        check("w1_D_pop", D_pop, 32'hA5A5_0001);
        check("w1_count", {27'd0, tx_count}, 32'd1);
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("p1_pndng", {31'd0, pndng}, 32'd0);
        check("p1_D_pop", D_pop, 32'd0);
        check("p1_count", {27'd0, tx_count}, 32'd0);
        check("p1_flags", {28'd0, tx_ovf, tx_udf, rx_ovf, rx_udf}, 32'd0);

        // fill TX, check order, overflow on lone 17th write
        for (int i = 0; i < 16; i++) begin
            host_wr = 1'b1; host_wr_data = i;
            tick();
        end
        host_wr = 1'b0;
        check("fill_full",  {31'd0, tx_full},  32'd1);
        check("fill_count", {27'd0, tx_count}, 32'd16);
        host_wr = 1'b1; host_wr_data = 32'hDEAD;
        tick();
        host_wr = 1'b0;
        check("ovf_flag",  {31'd0, tx_ovf},   32'd1);
        check("ovf_count", {27'd0, tx_count}, 32'd16);
        check("ovf_head",  D_pop,             32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_tx_ovf", {31'd0, tx_ovf}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", D_pop, i);
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        check("drain_empty", {31'd0, pndng}, 32'd0);
        check("drain_flags", {28'd0, tx_ovf, tx_udf, rx_ovf, rx_udf}, 32'd0);

        // underflow on empty TX pop
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("udf_flag",  {31'd0, tx_udf},   32'd1);
        check("udf_count", {27'd0, tx_count}, 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;

        // write and pop together while full
        for (int i = 0; i < 16; i++) begin
            host_wr = 1'b1; host_wr_data = i;
            tick();
        end
        host_wr = 1'b1; host_wr_data = 32'h55; pop = 1'b1;
        tick();
        host_wr = 1'b0; pop = 1'b0;
        check("wrpop_head",  D_pop,             32'h1);
        check("wrpop_count", {27'd0, tx_count}, 32'd16);
        check("wrpop_ovf",   {31'd0, tx_ovf},   32'd0);
        for (int i = 1; i < 16; i++) begin
            check("wrpop_drain", D_pop, i);
            pop = 1'b1;
            tick();
        end
        check("wrpop_last", D_pop, 32'h55);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("wrpop_empty", {27'd0, tx_count}, 32'd0);

        // push with read on empty RX
        push = 1'b1; D_push = 32'h1234; host_rd = 1'b1;
        tick();
        push = 1'b0; host_rd = 1'b0;
        check("rxu_udf",   {31'd0, rx_udf},   32'd1);
        check("rxu_count", {27'd0, rx_count}, 32'd1);
        check("rxu_data",  host_rd_data,      32'h1234);
        check("rxu_empty", {31'd0, rx_empty}, 32'd0);

        // RX overflow, clear collides with new overflow
        for (int i = 0; i < 15; i++) begin
            push = 1'b1; D_push = 32'h100 + i;
            tick();
        end
        check("rxf_count", {27'd0, rx_count}, 32'd16);
        push = 1'b1; D_push = 32'hBAD0;
        tick();
        check("rxo_flag", {31'd0, rx_ovf}, 32'd1);
        clr_flags = 1'b1; D_push = 32'hBAD1;
        tick();
        push = 1'b0;
        check("rxo_setwins", {31'd0, rx_ovf}, 32'd1);
        check("rxo_udf_clr", {31'd0, rx_udf}, 32'd0);
        tick();
        clr_flags = 1'b0;
        check("rxo_cleared", {31'd0, rx_ovf}, 32'd0);
        check("rx_head", host_rd_data, 32'h1234);
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        check("rx_next",  host_rd_data,      32'h100);
        check("rx_count", {27'd0, rx_count}, 32'd15);

        // async reset mid-cycle with TX holding five words
        for (int i = 0; i < 5; i++) begin
            host_wr = 1'b1; host_wr_data = 32'h200 + i;
            tick();
        end
        host_wr = 1'b0;
        check("pre_rst_count", {27'd0, tx_count}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pndng",    {31'd0, pndng},    32'd0);
        check("arst_count",    {27'd0, tx_count}, 32'd0);
        check("arst_D_pop",    D_pop,             32'd0);
        check("arst_rx_empty", {31'd0, rx_empty}, 32'd1);
        #1;
        reset = 1'b0;
        host_wr = 1'b1; host_wr_data = 32'h77;
        tick();
        host_wr = 1'b0;
        check("post_rst_D_pop", D_pop,             32'h77);
        check("post_rst_count", {27'd0, tx_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
